// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// RegfileSb : register file with a per-register pending-write scoreboard
//
// Purpose:
//   A 2**ADDR_W x DATA_W register file with NRD combinational read ports and
//   one write-back port. Each register also has a PEND_W-bit counter of
//   in-flight writes. Issuing an instruction bumps the counter of its
//   destination register and a write-back drops it. Reads report busy while
//   the addressed register still has an outstanding write. Register 0 is
//   hard-wired to zero and is never tracked.
//
// Optional feature:
//   REGFILE_SB_BYPASS_EN - when defined, a read that hits the write-back
//   happening in the same cycle returns the write data. It also ignores
//   the one pending write that this write-back retires.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_     in   synchronous active-low reset
//   re       in   [NRD]          per-port read enable
//   raddr    in   [NRD*ADDR_W]   per-port read address (port i at i*ADDR_W)
//   rdata    out  [NRD*DATA_W]   per-port read data    (port i at i*DATA_W)
//   rbusy    out  [NRD]          addressed register has an outstanding write
//   stall    out  any rbusy bit, or iss_full
//   we       in   write-back enable
//   waddr    in   [ADDR_W] write-back address
//   wdata    in   [DATA_W] write-back data
//   iss_vld  in   instruction issue that will write iss_addr
//   iss_addr in   [ADDR_W] destination of the issuing instruction
//   iss_full out  pending counter of iss_addr is saturated
//   flush    in   discard all outstanding writes
//   sb_err   out  sticky: write-back seen with no pending count
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int PEND_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    output logic                  stall,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  iss_vld,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_full,
    input  logic                  flush,
    output logic                  sb_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [PEND_W-1:0] pend_q [DEPTH];
    logic [PEND_W-1:0] pend_d [DEPTH];
    logic              sb_err_q;
    logic              sb_err_d;
    logic              issAccept;
    logic              wbValid;

    // Register array. Reset clears every entry. Writes to register 0 are
    // dropped, so it always holds zero. Flush does not block array writes.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Scoreboard next state. An issue to a saturated counter is refused, not
    // wrapped. An accepted issue and a write-back to the same register cancel
    // out, so that pairing never raises the error flag. A lone write-back to
    // a zero counter leaves the counter alone and records an error. Flush
    // clears everything and ignores issue and write-back in that cycle.
    always_comb begin
        pend_d    = pend_q;
        sb_err_d  = sb_err_q;
        issAccept = iss_vld && (iss_addr != '0) && (pend_q[iss_addr] != PEND_MAX);
        wbValid   = we && (waddr != '0);
        if (flush) begin
            for (int a = 0; a < DEPTH; a++) begin
                pend_d[a] = '0;
            end
        end else if (!(issAccept && wbValid && (iss_addr == waddr))) begin
            if (issAccept) begin
                pend_d[iss_addr] = pend_q[iss_addr] + PEND_ONE;
            end
            if (wbValid) begin
                if (pend_q[waddr] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    pend_d[waddr] = pend_q[waddr] - PEND_ONE;
                end
            end
        end
        pend_d[0] = '0;
    end

    // Scoreboard state. Reset clears all counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            for (int a = 0; a < DEPTH; a++) begin
                pend_q[a] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Read ports. While reset is asserted the outputs are forced to zero,
    // because a synchronous reset has not yet cleared the state.
    for (genvar i = 0; i < NRD; i++) begin : gRead
        logic [ADDR_W-1:0] ra;
        logic [PEND_W-1:0] pc;
        logic              hit;

        assign ra = raddr[i*ADDR_W +: ADDR_W];
        assign pc = pend_q[ra];

`ifdef REGFILE_SB_BYPASS_EN
        assign hit = we && (waddr == ra);
`else
        assign hit = 1'b0;
`endif

        assign rdata[i*DATA_W +: DATA_W] =
            (!rst_ || !re[i] || (ra == '0)) ? '0 :
            hit                             ? wdata :
                                              mem_q[ra];

        // A bypassed write-back retires one pending write. If that was the
        // only one, the register is no longer busy for this reader.
        assign rbusy[i] = rst_ && re[i] && (ra != '0) && (pc != '0) &&
                          !(hit && (pc == PEND_ONE));
    end

    assign iss_full = rst_ && (pend_q[iss_addr] == PEND_MAX);
    assign stall    = (|rbusy) || iss_full;
    assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb : self-checking bench for regfile_sb (default parameters)
//
// Inputs change just after the falling edge. Outputs are compared shortly
// afterwards against a reference model made of plain arrays. The model is
// then advanced at the rising edge. Directed scenarios come first, followed
// by randomized traffic on a small address window so that the counters
// saturate and underflow often. Build with +define+REGFILE_SB_BYPASS_EN to
// check the bypass variant.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int PEND_W = 2;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PMAX   = (2 ** PEND_W) - 1;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                  clk;
    logic                  rst_;
    logic [NRD-1:0]        re;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rbusy;
    logic                  stall;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic                  iss_vld;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  iss_full;
    logic                  flush;
    logic                  sb_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] mMem  [DEPTH];
    int                mPend [DEPTH];
    bit                mErr;

    regfile_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NRD   (NRD),
        .PEND_W(PEND_W)
    ) dut (
        .clk     (clk),
        .rst_    (rst_),
        .re      (re),
        .raddr   (raddr),
        .rdata   (rdata),
        .rbusy   (rbusy),
        .stall   (stall),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .iss_vld (iss_vld),
        .iss_addr(iss_addr),
        .iss_full(iss_full),
        .flush   (flush),
        .sb_err  (sb_err)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: count it and report any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int a = 0; a < DEPTH; a++) begin
            mMem[a]  = '0;
            mPend[a] = 0;
        end
        mErr = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs now applied
    task automatic modelUpdate();
        bit accept;
        bit wb;
        if (!rst_) begin
            modelReset();
        end else begin
            if (we && waddr != 0) mMem[waddr] = wdata;
            if (flush) begin
                for (int a = 0; a < DEPTH; a++) mPend[a] = 0;
            end else begin
                accept = iss_vld && (iss_addr != 0) && (mPend[iss_addr] < PMAX);
                wb     = we && (waddr != 0);
                if (!(accept && wb && iss_addr == waddr)) begin
                    if (accept) mPend[iss_addr] = mPend[iss_addr] + 1;
                    if (wb) begin
                        if (mPend[waddr] == 0) mErr = 1'b1;
                        else mPend[waddr] = mPend[waddr] - 1;
                    end
                end
            end
        end
    endtask

    // Compare every output against the model, then clock once
    task automatic applyStimulus();
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] expData;
        bit                expBusy;
        bit                anyBusy;
        bit                expFull;
        bit                hit;
        #1;
        anyBusy = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra  = raddr[i*ADDR_W +: ADDR_W];
            hit = BYPASS && we && (waddr == ra);
            if (!rst_ || !re[i] || ra == 0) expData = '0;
            else if (hit) expData = wdata;
            else expData = mMem[ra];
            expBusy = rst_ && re[i] && (ra != 0) && (mPend[ra] != 0) &&
                      !(hit && mPend[ra] == 1);
            anyBusy = anyBusy || expBusy;
            checkOutput($sformatf("rdata%0d", i), 64'(rdata[i*DATA_W +: DATA_W]), 64'(expData));
            checkOutput($sformatf("rbusy%0d", i), 64'(rbusy[i]), 64'(expBusy));
        end
        expFull = rst_ && (mPend[iss_addr] == PMAX);
        checkOutput("iss_full", 64'(iss_full), 64'(expFull));
        checkOutput("stall", 64'(stall), 64'(anyBusy || expFull));
        checkOutput("sb_err", 64'(sb_err), 64'(mErr));
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic idle();
        rst_     = 1'b1;
        re       = '0;
        raddr    = '0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        iss_vld  = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic setRead(input int port, input int addr);
        re[port] = 1'b1;
        raddr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    // Directed scenarios, then randomized traffic
    initial begin
        idle();
        rst_ = 1'b0;
        @(posedge clk);
        @(posedge clk);
        modelReset();
        @(negedge clk);

        // Reset held, then reads of addresses 3 and 0
        applyStimulus();
        setRead(0, 3);
        setRead(1, 0);
        applyStimulus();
        rst_ = 1'b1;
        applyStimulus();

        // Write reg5 then read it back; register 0 ignores writes
        idle();
        we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
        applyStimulus();
        idle();
        we = 1'b1; waddr = 0; wdata = 32'h1234;
        setRead(0, 5);
        #1 checkOutput("reg5_direct", 64'(rdata[DATA_W-1:0]), 64'h0000_0000_DEAD_BEEF);
        applyStimulus();
        idle();
        setRead(1, 0);
        applyStimulus();

        // Saturate reg7, then retire all three pending writes
        idle();
        iss_vld = 1'b1; iss_addr = 7;
        repeat (3) applyStimulus();
        #1 checkOutput("iss_full_direct", 64'(iss_full), 64'd1);
        checkOutput("stall_direct", 64'(stall), 64'd1);
        applyStimulus();
        idle();
        setRead(0, 7);
        we = 1'b1; waddr = 7;
        for (int k = 0; k < 3; k++) begin
            wdata = DATA_W'(32'h700 + k);
            applyStimulus();
        end
        we = 1'b0;
        #1 checkOutput("rbusy7_clear", 64'(rbusy[0]), 64'd0);
        applyStimulus();

        // Issue and write-back cancel; lone write-back to reg4 sets sb_err
        idle();
        iss_vld = 1'b1; iss_addr = 9;
        applyStimulus();
        we = 1'b1; waddr = 9; wdata = 32'h99;
        applyStimulus();
        idle();
        setRead(0, 9);
        #1 checkOutput("rbusy9_held", 64'(rbusy[0]), 64'd1);
        applyStimulus();
        idle();
        we = 1'b1; waddr = 4; wdata = 32'h44;
        applyStimulus();
        idle();
        #1 checkOutput("sb_err_set", 64'(sb_err), 64'd1);
        repeat (3) applyStimulus();

        // Bypass: reg6 old value 0x11, one pending write, then read with write-back
        rst_ = 1'b0;
        applyStimulus();
        idle();
        iss_vld = 1'b1; iss_addr = 6;
        applyStimulus();
        idle();
        we = 1'b1; waddr = 6; wdata = 32'h11;
        applyStimulus();
        idle();
        iss_vld = 1'b1; iss_addr = 6;
        applyStimulus();
        idle();
        setRead(0, 6);
        we = 1'b1; waddr = 6; wdata = 32'hA5;
        #1 checkOutput("bypass_data", 64'(rdata[DATA_W-1:0]), BYPASS ? 64'hA5 : 64'h11);
        applyStimulus();

        // Flush clears pending state; reset then wipes reg2
        idle();
        iss_vld = 1'b1; iss_addr = 2;
        applyStimulus();
        iss_addr = 3;
        applyStimulus();
        idle();
        setRead(0, 2);
        setRead(1, 3);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        #1 checkOutput("flush_clear", 64'(rbusy), 64'd0);
        applyStimulus();
        idle();
        we = 1'b1; waddr = 2; wdata = 32'h55;
        applyStimulus();
        idle();
        rst_ = 1'b0;
        applyStimulus();
        idle();
        setRead(0, 2);
        #1 checkOutput("reg2_reset", 64'(rdata[DATA_W-1:0]), 64'd0);
        applyStimulus();

        // Randomized traffic, mostly within registers 0..7
        for (int n = 0; n < 800; n++) begin
            rst_     = ($urandom % 60) != 0;
            flush    = ($urandom % 20) == 0;
            re       = NRD'($urandom);
            for (int i = 0; i < NRD; i++) begin
                raddr[i*ADDR_W +: ADDR_W] = ($urandom % 4 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom % 8);
            end
            we       = ($urandom % 3) != 0;
            waddr    = ($urandom % 4 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom % 8);
            wdata    = DATA_W'($urandom);
            iss_vld  = ($urandom % 3) != 0;
            iss_addr = ($urandom % 4 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom % 8);
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
